// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants and fetch FSM encoding
package fetch_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {S_REQ, S_DISCARD, S_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with word-aligned load and +4 increment
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);
  assign pc_plus4 = pc + PC_W'(4);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= load_val & ~PC_W'(3);
    else if (inc) pc <= pc_plus4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with single outstanding request, stall skid and redirect flush
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] oinstru,
  output logic [PC_W-1:0]    sum2sumOF,
  output logic               valid_F
);
  fetch_state_t state;
  logic [PC_W-1:0] pc, pc_plus4, req_addr, skid_pc4;
  logic [INSTR_W-1:0] skid_instr;
  logic started, acked;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(redirect), .inc(state == S_REQ && acked),
    .load_val(redirect_pc), .pc(pc), .pc_plus4(pc_plus4)
  );
  // started keeps the request low until the first clock after reset
  assign imem_req = started && state != S_HOLD;
  assign imem_addr = state == S_DISCARD ? req_addr : pc;
  assign acked = imem_req && imem_ack;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_REQ;
      started <= 1'b0;
      req_addr <= '0;
      oinstru <= NOP_INSTR;
      sum2sumOF <= '0;
      valid_F <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc4 <= '0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        // an un-acked request must drain at its original address
        state <= imem_req && !imem_ack ? S_DISCARD : S_REQ;
        req_addr <= imem_addr;
        oinstru <= NOP_INSTR;
        valid_F <= 1'b0;
        skid_instr <= NOP_INSTR;
        skid_pc4 <= '0;
      end else begin
        case (state)
          S_REQ:
            if (acked && stall) begin
              skid_instr <= imem_rdata;
              skid_pc4 <= pc_plus4;
              state <= S_HOLD;
            end else if (!stall) begin
              oinstru <= acked ? imem_rdata : NOP_INSTR;
              sum2sumOF <= acked ? pc_plus4 : sum2sumOF;
              valid_F <= acked;
            end
          S_HOLD:
            if (!stall) begin
              oinstru <= skid_instr;
              sum2sumOF <= skid_pc4;
              valid_F <= 1'b1;
              state <= S_REQ;
            end
          S_DISCARD:
            if (imem_ack) state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h00000000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  from the hazard unit; holds the PC and the IF/ID outputs.
REQ-005 redirect  input  1  taken branch or jump resolved downstream; flushes IF/ID.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address, equal to the PC.
REQ-009 imem_ack  input  1  memory response strobe; latency is 1 or more cycles after the request.
REQ-010 imem_rdata  input  32  instruction word, valid only in the imem_ack cycle.
REQ-011 oinstru  output  32  registered IF/ID instruction; feeds the Decode stage.
REQ-012 sum2sumOF  output  32  registered PC+4 of the instruction in oinstru.
REQ-013 valid_F  output  1  registered flag: oinstru holds a real instruction (0 = bubble).

Function
REQ-014 Internal state: PC register; FSM {S_REQ, S_DISCARD, S_HOLD}; skid register of 32-bit instruction plus 32-bit PC+4.
REQ-015 S_REQ drives imem_req=1 and imem_addr=PC.
REQ-016 S_REQ holds imem_addr stable on every cycle until imem_ack.
REQ-017 S_REQ, imem_ack=1, stall=0, redirect=0: load oinstru=imem_rdata, sum2sumOF=PC+4, valid_F=1; then PC<=PC+4; stay in S_REQ.
REQ-018 S_REQ, imem_ack=1, stall=1, redirect=0: IF/ID holds; rdata and PC+4 go to the skid register; PC<=PC+4; go to S_HOLD.
REQ-019 S_REQ, imem_ack=0, stall=0, redirect=0: IF/ID loads a bubble (valid_F=0, oinstru=0); outputs hold during stall.
REQ-020 S_HOLD drives imem_req=0.
REQ-021 S_HOLD with stall=1: everything holds.
REQ-022 S_HOLD with stall=0: IF/ID loads from the skid register with valid_F=1; go to S_REQ.
REQ-023 redirect=1 has priority over stall in every state.
REQ-024 On redirect, the IF/ID outputs go to a bubble.
REQ-025 On redirect, PC<={redirect_pc[31:2],2'b00}.
REQ-026 On redirect, the skid register contents are discarded.
REQ-027 Redirect in S_REQ with imem_ack=0: go to S_DISCARD; the outstanding request keeps its old address.
REQ-028 Redirect in S_REQ with imem_ack=1: rdata is dropped; go to S_REQ at the new PC next cycle.
REQ-029 Redirect in S_HOLD or S_DISCARD: go to S_DISCARD if a request is outstanding, else to S_REQ.
REQ-030 S_DISCARD keeps imem_req=1 at the old address until imem_ack.
REQ-031 In S_DISCARD, the acked rdata is dropped, IF/ID shows a bubble, and the FSM goes to S_REQ with the new PC.
REQ-032 A later redirect in S_DISCARD overwrites the PC only.
REQ-033 PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000; sum2sumOF wraps the same way.
REQ-034 Latency: instruction visible on oinstru the cycle after its imem_ack, absent stall/redirect.
REQ-035 At most one outstanding memory request at any time.

Reset
REQ-036 rst=1 asynchronously sets: PC=RESET_PC, FSM=S_REQ, oinstru=0, sum2sumOF=0, valid_F=0, skid=0.
REQ-037 imem_req is 0 while rst=1 and is asserted on the first clock after rst deasserts.
REQ-038 Reset mid-request abandons the in-flight access; the memory model must tolerate this.

Structure
REQ-039 Shared pipeline package holds: NOP_INSTR (32'h0), INSTR_W (32), PC_W (32), FSM state encoding.
REQ-040 One sub-module, pc_reg: PC register with load and increment.
REQ-041 FSM and IF/ID/skid registers stay in fetch_stage.

Verification
REQ-042 Reset, 0-wait memory returning 0x11,0x22,0x33 → oinstru 0x11/0x22/0x33 on consecutive cycles; sum2sumOF 4/8/12; valid_F=1.
REQ-043 Stall held 3 cycles while an ack arrives → IF/ID frozen, imem_req=0; instruction appears the cycle after stall drops; none lost or duplicated.
REQ-044 Redirect to 0x101 in the cycle after a request at 0x8, memory latency 3 → bubble; old rdata dropped; next imem_addr=0x100; next oinstru from 0x100 with sum2sumOF=0x104.
REQ-045 Redirect and imem_ack in the same cycle, with stall=1 → rdata dropped; valid_F=0; fetch resumes at the target.
REQ-046 RESET_PC=32'hFFFFFFFC → first sum2sumOF=0; next imem_addr=0.
REQ-047 rst asserted during S_DISCARD → all outputs reset asynchronously; fetch restarts at RESET_PC.
